// File: rtl/spwtcr_link_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : spwtcr_link_fsm
//  Brief    : SpaceWire exchange-level link controller. Sequences the link
//             through ErrorReset, ErrorWait, Ready, Started, Connecting and
//             Run, and tracks transmit and receive flow-control credit.
//  Revision : 1.0 - initial release
// ============================================================================
module spwtcr_link_fsm #(
  parameter int unsigned CYCLES_6U4  = 640,
  parameter int unsigned CYCLES_12U8 = 1280
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       link_start_i,
  input  logic       autostart_i,
  input  logic       link_disable_i,
  input  logic       got_null_i,
  input  logic       got_fct_i,
  input  logic       got_nchar_i,
  input  logic       got_timecode_i,
  input  logic       rx_error_i,
  input  logic       fct_sent_i,
  input  logic       nchar_sent_i,
  output logic       enable_rx_o,
  output logic       enable_tx_o,
  output logic       send_fcts_o,
  output logic       send_nchars_o,
  output logic       send_timecodes_o,
  output logic [2:0] link_state_o,
  output logic [5:0] tx_credit_o,
  output logic [5:0] rx_credit_o,
  output logic       credit_error_o
);

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } state_t;

  localparam logic [15:0] C_T6U4_LAST  = 16'(CYCLES_6U4 - 1);
  localparam logic [15:0] C_T12U8_LAST = 16'(CYCLES_12U8 - 1);
  localparam logic [6:0]  C_MAX_CREDIT = 7'd56;
  localparam logic [5:0]  C_FCT_LIMIT  = 6'd48;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [5:0]  tx_credit_q, tx_credit_d;
  logic [5:0]  rx_credit_q, rx_credit_d;
  logic        credit_error_q;
  logic        enable_rx_q, enable_rx_d;
  logic        enable_tx_q, enable_tx_d;
  logic        send_fcts_q, send_fcts_d;
  logic        send_nchars_q, send_nchars_d;
  logic        send_timecodes_q, send_timecodes_d;

  logic        w_in_credit;
  logic        w_tx_dec;
  logic [6:0]  w_tx_sum;
  logic        w_tx_over;
  logic [6:0]  w_rx_sum;
  logic        w_rx_under;
  logic        w_credit_err;
  logic        w_err;
  logic        w_rx_event;
  logic        w_timeout;

  // Credit arithmetic: both increment and decrement apply in the same cycle.
  always_comb begin
    w_in_credit  = (state_q == ST_CONNECTING) || (state_q == ST_RUN);
    w_tx_dec     = nchar_sent_i && (tx_credit_q != 6'd0);
    w_tx_sum     = {1'b0, tx_credit_q} + (got_fct_i ? 7'd8 : 7'd0) - {6'd0, w_tx_dec};
    w_tx_over    = w_tx_sum > C_MAX_CREDIT;
    w_rx_sum     = {1'b0, rx_credit_q} + (fct_sent_i ? 7'd8 : 7'd0) - {6'd0, got_nchar_i};
    w_rx_under   = got_nchar_i && !fct_sent_i && (rx_credit_q == 6'd0);
    w_credit_err = w_in_credit && (w_tx_over || w_rx_under);
    w_err        = rx_error_i || w_credit_err;
    w_rx_event   = got_fct_i || got_nchar_i || got_timecode_i;
    w_timeout    = (timer_q == C_T12U8_LAST);

    tx_credit_d = tx_credit_q;
    rx_credit_d = rx_credit_q;
    if (state_q == ST_ERROR_RESET) begin
      tx_credit_d = 6'd0;
      rx_credit_d = 6'd0;
    end else if (w_in_credit) begin
      // An overflowing FCT leaves the credit untouched; the link drops anyway.
      if (!w_tx_over) tx_credit_d = w_tx_sum[5:0];
      if (!w_rx_under) begin
        rx_credit_d = (w_rx_sum > C_MAX_CREDIT) ? C_MAX_CREDIT[5:0] : w_rx_sum[5:0];
      end
    end
  end

  // Next-state selection; within each state errors win over disable, then timeout, then advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ERROR_RESET: begin
        if (timer_q == C_T6U4_LAST) state_d = ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (w_err || w_rx_event)          state_d = ST_ERROR_RESET;
        else if (timer_q == C_T12U8_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (w_err || w_rx_event || link_disable_i)          state_d = ST_ERROR_RESET;
        else if (link_start_i || (autostart_i && got_null_i)) state_d = ST_STARTED;
      end
      ST_STARTED: begin
        if (w_err || w_rx_event || link_disable_i || w_timeout) state_d = ST_ERROR_RESET;
        else if (got_null_i)                                    state_d = ST_CONNECTING;
      end
      ST_CONNECTING: begin
        if (w_err || got_nchar_i || got_timecode_i || link_disable_i || w_timeout)
          state_d = ST_ERROR_RESET;
        else if (got_fct_i)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_err || link_disable_i) state_d = ST_ERROR_RESET;
      end
      default: state_d = ST_ERROR_RESET;
    endcase

    // The dwell timer restarts on every state change and saturates otherwise.
    if (state_d != state_q)        timer_d = 16'd0;
    else if (timer_q == 16'hFFFF)  timer_d = timer_q;
    else                           timer_d = timer_q + 16'd1;
  end

  // Output values are derived from the next state so they register alongside it.
  always_comb begin
    enable_rx_d      = (state_d != ST_ERROR_RESET);
    enable_tx_d      = (state_d == ST_STARTED) || (state_d == ST_CONNECTING) || (state_d == ST_RUN);
    send_fcts_d      = ((state_d == ST_CONNECTING) || (state_d == ST_RUN)) &&
                       (rx_credit_d <= C_FCT_LIMIT);
    send_nchars_d    = (state_d == ST_RUN) && (tx_credit_d != 6'd0);
    send_timecodes_d = (state_d == ST_RUN);
  end

  // State, timer, credit and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_ERROR_RESET;
      timer_q          <= 16'd0;
      tx_credit_q      <= 6'd0;
      rx_credit_q      <= 6'd0;
      credit_error_q   <= 1'b0;
      enable_rx_q      <= 1'b0;
      enable_tx_q      <= 1'b0;
      send_fcts_q      <= 1'b0;
      send_nchars_q    <= 1'b0;
      send_timecodes_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      tx_credit_q      <= tx_credit_d;
      rx_credit_q      <= rx_credit_d;
      credit_error_q   <= w_credit_err;
      enable_rx_q      <= enable_rx_d;
      enable_tx_q      <= enable_tx_d;
      send_fcts_q      <= send_fcts_d;
      send_nchars_q    <= send_nchars_d;
      send_timecodes_q <= send_timecodes_d;
    end
  end

  assign link_state_o     = state_q;
  assign tx_credit_o      = tx_credit_q;
  assign rx_credit_o      = rx_credit_q;
  assign credit_error_o   = credit_error_q;
  assign enable_rx_o      = enable_rx_q;
  assign enable_tx_o      = enable_tx_q;
  assign send_fcts_o      = send_fcts_q;
  assign send_nchars_o    = send_nchars_q;
  assign send_timecodes_o = send_timecodes_q;

endmodule
`default_nettype wire

// File: tb/tb_spwtcr_link_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spwtcr_link_fsm
//  Brief    : Directed self-checking bench for spwtcr_link_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spwtcr_link_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       link_start = 1'b0, autostart = 1'b0, link_disable = 1'b0;
  logic       got_null = 1'b0, got_fct = 1'b0, got_nchar = 1'b0, got_timecode = 1'b0;
  logic       rx_error = 1'b0, fct_sent = 1'b0, nchar_sent = 1'b0;
  logic       enable_rx, enable_tx, send_fcts, send_nchars, send_timecodes;
  logic [2:0] link_state;
  logic [5:0] tx_credit, rx_credit;
  logic       credit_error;

  int checks = 0;
  int failures = 0;

  spwtcr_link_fsm #(.CYCLES_6U4(640), .CYCLES_12U8(1280)) dut (
    .clk_i(clk), .rst_i(rst),
    .link_start_i(link_start), .autostart_i(autostart), .link_disable_i(link_disable),
    .got_null_i(got_null), .got_fct_i(got_fct), .got_nchar_i(got_nchar),
    .got_timecode_i(got_timecode), .rx_error_i(rx_error),
    .fct_sent_i(fct_sent), .nchar_sent_i(nchar_sent),
    .enable_rx_o(enable_rx), .enable_tx_o(enable_tx), .send_fcts_o(send_fcts),
    .send_nchars_o(send_nchars), .send_timecodes_o(send_timecodes),
    .link_state_o(link_state), .tx_credit_o(tx_credit), .rx_credit_o(rx_credit),
    .credit_error_o(credit_error)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n clock edges, leaving time 1 unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    link_start = 0; autostart = 0; link_disable = 0; got_null = 0; got_fct = 0;
    got_nchar = 0; got_timecode = 0; rx_error = 0; fct_sent = 0; nchar_sent = 0;
  endtask

  // Reset, then wait out ErrorReset (640) + ErrorWait (1280): the link sits in Ready.
  task automatic go_ready();
    clear_inputs();
    rst = 1; step(1); rst = 0;
    step(1920);
  endtask

  // Ready -> Started -> Connecting -> Run, with txCredit 8 and rxCredit 0.
  task automatic get_to_run();
    go_ready();
    link_start = 1; step(1); link_start = 0;
    got_null = 1; step(1);
    got_fct = 1; step(1); got_fct = 0;
  endtask

  task automatic test_reset();
    int bad;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1; #1;
    checks++; if ({link_state, enable_rx, enable_tx, send_fcts, send_nchars, send_timecodes, credit_error, tx_credit, rx_credit} !== 21'd0) begin
      failures++; $display("FAIL reset_outputs: state=%0d rx=%b tx=%b txc=%0d rxc=%0d, all zero required", link_state, enable_rx, enable_tx, tx_credit, rx_credit);
    end
    step(1); rst = 0;
    bad = 0;
    for (int i = 0; i < 639; i++) begin step(1); if (link_state !== 3'd0 || enable_rx !== 1'b0) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL er_dwell: %0d cycles left state 0 early, 0 required", bad); end
    step(1);
    checks++; if (link_state !== 3'd1 || enable_rx !== 1'b1) begin
      failures++; $display("FAIL enter_errorwait: state=%0d enable_rx=%b, required 1/1", link_state, enable_rx);
    end
    bad = 0;
    for (int i = 0; i < 1279; i++) begin step(1); if (link_state !== 3'd1) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL ew_dwell: %0d cycles not in state 1, 0 required", bad); end
    step(1);
    checks++; if (link_state !== 3'd2) begin failures++; $display("FAIL enter_ready: state=%0d required 2", link_state); end
    step(50);
    checks++; if (link_state !== 3'd2 || enable_tx !== 1'b0 || enable_rx !== 1'b1) begin
      failures++; $display("FAIL ready_hold: state=%0d tx=%b rx=%b, required 2/0/1", link_state, enable_tx, enable_rx);
    end
  endtask

  task automatic test_link_up();
    go_ready();
    link_start = 1; step(1); link_start = 0;
    checks++; if (link_state !== 3'd3 || enable_tx !== 1'b1 || send_fcts !== 1'b0) begin
      failures++; $display("FAIL started: state=%0d tx=%b fcts=%b, required 3/1/0", link_state, enable_tx, send_fcts);
    end
    step(99);
    checks++; if (link_state !== 3'd3) begin failures++; $display("FAIL started_hold: state=%0d required 3", link_state); end
    got_null = 1; step(1);
    checks++; if (link_state !== 3'd4 || send_fcts !== 1'b1 || send_nchars !== 1'b0) begin
      failures++; $display("FAIL connecting: state=%0d fcts=%b nch=%b, required 4/1/0", link_state, send_fcts, send_nchars);
    end
    step(49);
    got_fct = 1; step(1); got_fct = 0;
    checks++; if (link_state !== 3'd5 || tx_credit !== 6'd8 || send_nchars !== 1'b1 || send_timecodes !== 1'b1) begin
      failures++; $display("FAIL run_entry: state=%0d txc=%0d nch=%b tc=%b, required 5/8/1/1", link_state, tx_credit, send_nchars, send_timecodes);
    end
  endtask

  task automatic test_tx_overflow();
    get_to_run();
    for (int i = 0; i < 6; i++) begin got_fct = 1; step(1); got_fct = 0; end
    checks++; if (tx_credit !== 6'd56 || link_state !== 3'd5 || credit_error !== 1'b0) begin
      failures++; $display("FAIL tx_56: txc=%0d state=%0d cerr=%b, required 56/5/0", tx_credit, link_state, credit_error);
    end
    got_fct = 1; step(1); got_fct = 0;
    checks++; if (credit_error !== 1'b1 || link_state !== 3'd0 || enable_tx !== 1'b0) begin
      failures++; $display("FAIL tx_overflow: cerr=%b state=%0d tx=%b, required 1/0/0", credit_error, link_state, enable_tx);
    end
    step(1);
    checks++; if (credit_error !== 1'b0 || tx_credit !== 6'd0 || rx_credit !== 6'd0 || link_state !== 3'd0) begin
      failures++; $display("FAIL tx_overflow_after: cerr=%b txc=%0d rxc=%0d state=%0d, required 0/0/0/0", credit_error, tx_credit, rx_credit, link_state);
    end
  endtask

  task automatic test_tx_drain();
    get_to_run();
    got_fct = 1; nchar_sent = 1; step(1); got_fct = 0; nchar_sent = 0;
    checks++; if (tx_credit !== 6'd15) begin failures++; $display("FAIL tx_simul: txc=%0d required 15", tx_credit); end
    for (int i = 0; i < 7; i++) begin nchar_sent = 1; step(1); nchar_sent = 0; end
    checks++; if (tx_credit !== 6'd8 || send_nchars !== 1'b1) begin
      failures++; $display("FAIL tx_mid: txc=%0d nch=%b, required 8/1", tx_credit, send_nchars);
    end
    for (int i = 0; i < 8; i++) begin nchar_sent = 1; step(1); nchar_sent = 0; end
    checks++; if (tx_credit !== 6'd0 || send_nchars !== 1'b0) begin
      failures++; $display("FAIL tx_empty: txc=%0d nch=%b, required 0/0", tx_credit, send_nchars);
    end
    nchar_sent = 1; step(1); nchar_sent = 0;
    checks++; if (tx_credit !== 6'd0 || credit_error !== 1'b0 || link_state !== 3'd5) begin
      failures++; $display("FAIL tx_underflow: txc=%0d cerr=%b state=%0d, required 0/0/5", tx_credit, credit_error, link_state);
    end
  endtask

  task automatic test_rx_credit();
    get_to_run();
    for (int i = 0; i < 6; i++) begin fct_sent = 1; step(1); fct_sent = 0; end
    checks++; if (rx_credit !== 6'd48 || send_fcts !== 1'b1) begin
      failures++; $display("FAIL rx_48: rxc=%0d fcts=%b, required 48/1", rx_credit, send_fcts);
    end
    fct_sent = 1; step(1); fct_sent = 0;
    checks++; if (rx_credit !== 6'd56 || send_fcts !== 1'b0) begin
      failures++; $display("FAIL rx_56: rxc=%0d fcts=%b, required 56/0", rx_credit, send_fcts);
    end
    fct_sent = 1; step(1); fct_sent = 0;
    checks++; if (rx_credit !== 6'd56 || credit_error !== 1'b0 || link_state !== 3'd5) begin
      failures++; $display("FAIL rx_clamp: rxc=%0d cerr=%b state=%0d, required 56/0/5", rx_credit, credit_error, link_state);
    end
    got_nchar = 1; step(1); got_nchar = 0;
    checks++; if (rx_credit !== 6'd55) begin failures++; $display("FAIL rx_dec: rxc=%0d required 55", rx_credit); end
    get_to_run();
    got_nchar = 1; step(1); got_nchar = 0;
    checks++; if (credit_error !== 1'b1 || link_state !== 3'd0) begin
      failures++; $display("FAIL rx_underflow: cerr=%b state=%0d, required 1/0", credit_error, link_state);
    end
  endtask

  task automatic test_timeouts();
    go_ready();
    link_start = 1; step(1); link_start = 0;
    step(1279);
    checks++; if (link_state !== 3'd3) begin failures++; $display("FAIL started_pre_timeout: state=%0d required 3", link_state); end
    step(1);
    checks++; if (link_state !== 3'd0 || enable_tx !== 1'b0) begin
      failures++; $display("FAIL started_timeout: state=%0d tx=%b, required 0/0", link_state, enable_tx);
    end
    clear_inputs();
    rst = 1; step(1); rst = 0;
    step(640);
    step(10);
    checks++; if (link_state !== 3'd1) begin failures++; $display("FAIL ew_before_fct: state=%0d required 1", link_state); end
    got_fct = 1; step(1); got_fct = 0;
    checks++; if (link_state !== 3'd0 || enable_rx !== 1'b0) begin
      failures++; $display("FAIL ew_fct: state=%0d rx=%b, required 0/0", link_state, enable_rx);
    end
  endtask

  task automatic test_ready_controls();
    go_ready();
    autostart = 1; step(1);
    checks++; if (link_state !== 3'd2) begin failures++; $display("FAIL autostart_no_null: state=%0d required 2", link_state); end
    got_null = 1; step(1);
    checks++; if (link_state !== 3'd3) begin failures++; $display("FAIL autostart_null: state=%0d required 3", link_state); end
    go_ready();
    link_disable = 1; link_start = 1; step(1);
    checks++; if (link_state !== 3'd0) begin failures++; $display("FAIL ready_disable: state=%0d required 0", link_state); end
    clear_inputs();
  endtask

  task automatic test_run_abort();
    get_to_run();
    rx_error = 1; step(1); rx_error = 0;
    checks++; if (link_state !== 3'd0 || enable_tx !== 1'b0 || enable_rx !== 1'b0) begin
      failures++; $display("FAIL run_rxerror: state=%0d tx=%b rx=%b, required 0/0/0", link_state, enable_tx, enable_rx);
    end
    get_to_run();
    #2 rst = 1; #1;
    checks++; if (link_state !== 3'd0 || enable_tx !== 1'b0 || enable_rx !== 1'b0 || tx_credit !== 6'd0) begin
      failures++; $display("FAIL run_async_reset: state=%0d tx=%b rx=%b txc=%0d, required 0/0/0/0", link_state, enable_tx, enable_rx, tx_credit);
    end
    step(1); rst = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_link_up();
    test_tx_overflow();
    test_tx_drain();
    test_rx_credit();
    test_timeouts();
    test_ready_controls();
    test_run_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
